keccak_absorb_ctrl: RTL

//  Sequential absorb front-end for the Keccak-f[1600] core; successor to the combinational mode-select/XOR stage.

---
 rtl/keccak_absorb_ctrl_if.sv | 12 +
 rtl/keccak_absorb_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keccak_absorb_ctrl_if.sv
// rtl/keccak_absorb_ctrl_if.sv - host message stream into the Keccak absorb front-end
interface keccak_absorb_ctrl_if;
  logic [2:0]  mode_i;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_nbytes;

  modport master (output mode_i, in_valid, in_data, in_last, in_nbytes, input in_ready);
  modport slave  (input mode_i, in_valid, in_data, in_last, in_nbytes, output in_ready);
endinterface

// File: rtl/keccak_absorb_ctrl.sv
// rtl/keccak_absorb_ctrl.sv - sequential absorb, padding and permutation handshake for Keccak-f[1600]
module keccak_absorb_ctrl #(
  parameter int LANE_W = 64,
  parameter bit HW_PAD = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keccak_absorb_ctrl_if.slave    msg,
  output logic                   perm_start,
  output logic [25*LANE_W-1:0]   perm_state_o,
  input  logic                   perm_done,
  input  logic [25*LANE_W-1:0]   perm_state_i,
  output logic [25*LANE_W-1:0]   state_o,
  output logic                   digest_valid,
  output logic                   err_mode,
  output logic                   busy
);
  localparam int SW = 25 * LANE_W;

  typedef enum logic [2:0] {IDLE, FILL, PERM, PAD, DONE, DROP} fsm_t;

  fsm_t          fsm_q, fsm_d, fill_next;
  logic [SW-1:0] st_q;
  logic [4:0]    lane_idx, pad_lane;
  logic [2:0]    mode_q, pad_byte;
  logic          pad_pending, final_blk, perm_started, err_d, ready;

  logic          accept, mode_bad, at_end, full_last, keep_all;
  logic [2:0]    mode_cur;
  logic [4:0]    lane_cur, rate_cur;
  logic [63:0]   byte_mask, data_m;
  logic [10:0]   lane_sh, pad_sh, end_sh;
  logic [SW-1:0] beat_vec, pad_vec;

  function automatic logic [4:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    rate_of = 5'd18;
      3'd1:    rate_of = 5'd17;
      3'd2:    rate_of = 5'd13;
      3'd3:    rate_of = 5'd9;
      3'd4:    rate_of = 5'd21;
      default: rate_of = 5'd17;
    endcase
  endfunction

  function automatic logic [7:0] domain_of(input logic [2:0] m);
    domain_of = (m >= 3'd4) ? 8'h1F : 8'h06;
  endfunction

  // Accepting states are exactly the ones that can take a beat; kept off the FSM comb to avoid a loop
  assign ready = (fsm_q == IDLE) || (fsm_q == FILL) || (fsm_q == DROP);

  // Beat decode: lane position, byte masking, pad vector and where an accepted beat sends the FSM
  always_comb begin
    mode_cur  = (fsm_q == IDLE) ? msg.mode_i : mode_q;
    lane_cur  = (fsm_q == IDLE) ? 5'd0 : lane_idx;
    rate_cur  = rate_of(mode_cur);
    accept    = msg.in_valid & ready;
    mode_bad  = (msg.mode_i > 3'd5);
    at_end    = (lane_cur == rate_cur - 5'd1);
    full_last = !HW_PAD || (msg.in_nbytes >= 4'd8);
    keep_all  = !msg.in_last || full_last;
    byte_mask = '0;
    for (int b = 0; b < 8; b++) begin
      if (keep_all || (4'(b) < msg.in_nbytes)) byte_mask[8*b +: 8] = 8'hFF;
    end
    data_m   = msg.in_data & byte_mask;
    lane_sh  = {lane_cur, 6'd0};
    beat_vec = {{(SW-64){1'b0}}, data_m} << lane_sh;
    // Domain byte and the closing 0x80 XOR independently, so a shared byte becomes 0x86/0x9F
    pad_sh   = {pad_lane, pad_byte, 3'd0};
    end_sh   = {rate_of(mode_q) - 5'd1, 3'd7, 3'd0};
    pad_vec  = ({{(SW-8){1'b0}}, domain_of(mode_q)} << pad_sh)
             ^ ({{(SW-8){1'b0}}, 8'h80} << end_sh);
    if (!msg.in_last)                             fill_next = at_end ? PERM : FILL;
    else if (!HW_PAD)                             fill_next = PERM;
    else if ((msg.in_nbytes < 4'd8) || !at_end)   fill_next = PAD;
    else                                          fill_next = PERM;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // FSM next-state and error pulse request
  always_comb begin
    fsm_d = fsm_q;
    err_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (msg.in_valid) begin
          if (mode_bad) begin
            if (msg.in_last) err_d = 1'b1;
            else             fsm_d = DROP;
          end else begin
            fsm_d = fill_next;
          end
        end
      end
      FILL: if (msg.in_valid) fsm_d = fill_next;
      PAD:  fsm_d = PERM;
      PERM: begin
        if (perm_done) begin
          if (pad_pending)    fsm_d = PAD;
          else if (final_blk) fsm_d = DONE;
          else                fsm_d = FILL;
        end
      end
      DONE: fsm_d = IDLE;
      DROP: begin
        if (msg.in_valid && msg.in_last) begin
          err_d = 1'b1;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register, lane bookkeeping and pad position tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= '0;
      lane_idx     <= '0;
      pad_lane     <= '0;
      pad_byte     <= '0;
      mode_q       <= '0;
      pad_pending  <= 1'b0;
      final_blk    <= 1'b0;
      perm_started <= 1'b0;
      err_mode     <= 1'b0;
    end else begin
      err_mode     <= err_d;
      perm_started <= (fsm_q == PERM);
      case (fsm_q)
        IDLE, FILL: begin
          if (accept && !((fsm_q == IDLE) && mode_bad)) begin
            if (fsm_q == IDLE) begin
              // A new message starts from an all-zero state
              st_q      <= beat_vec;
              mode_q    <= msg.mode_i;
              final_blk <= 1'b0;
            end else begin
              st_q <= st_q ^ beat_vec;
            end
            if (!msg.in_last) begin
              lane_idx <= at_end ? 5'd0 : lane_cur + 5'd1;
            end else begin
              lane_idx <= 5'd0;
              if (!HW_PAD) begin
                final_blk <= 1'b1;
              end else if (msg.in_nbytes < 4'd8) begin
                pad_lane <= lane_cur;
                pad_byte <= msg.in_nbytes[2:0];
              end else if (!at_end) begin
                pad_lane <= lane_cur + 5'd1;
                pad_byte <= 3'd0;
              end else begin
                // Message filled the block exactly: padding goes in a whole extra block
                pad_lane    <= 5'd0;
                pad_byte    <= 3'd0;
                pad_pending <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          st_q        <= st_q ^ pad_vec;
          pad_pending <= 1'b0;
          final_blk   <= 1'b1;
        end
        PERM: if (perm_done) st_q <= perm_state_i;
        default: ;
      endcase
    end
  end

  assign msg.in_ready  = ready;
  assign perm_start    = (fsm_q == PERM) && !perm_started;
  assign perm_state_o  = st_q;
  assign state_o       = st_q;
  assign digest_valid  = (fsm_q == DONE);
  assign busy          = (fsm_q != IDLE);
endmodule
